// File: rtl/jtag_arbiter.sv
// Two-master JTAG port arbiter: hands the DUT debug port to one master at a time,
// switching only in TLR/RTI and only after a parked gap, and tracks the TAP state.
module jtag_arbiter #(
   parameter int SWITCH_GAP = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       m0_req_i,
   input  logic       m1_req_i,
   output logic       m0_gnt_o,
   output logic       m1_gnt_o,
   input  logic       m0_tck_i,
   input  logic       m0_tms_i,
   input  logic       m0_tdi_i,
   input  logic       m0_trstn_i,
   output logic       m0_tdo_o,
   input  logic       m1_tck_i,
   input  logic       m1_tms_i,
   input  logic       m1_tdi_i,
   input  logic       m1_trstn_i,
   output logic       m1_tdo_o,
   output logic       tck_o,
   output logic       tms_o,
   output logic       tdi_o,
   output logic       trstn_o,
   input  logic       tdo_i,
   output logic [3:0] tap_state_o,
   output logic       busy_o
);

   localparam int CW = (SWITCH_GAP > 1) ? $clog2(SWITCH_GAP) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OWN0,
      ST_OWN1,
      ST_GAP
   } arb_state_t;

   typedef enum logic [3:0] {
      TAP_TLR    = 4'hF,
      TAP_RTI    = 4'hC,
      TAP_SELDR  = 4'h7,
      TAP_CAPDR  = 4'h6,
      TAP_SHDR   = 4'h2,
      TAP_EX1DR  = 4'h1,
      TAP_PAUDR  = 4'h3,
      TAP_EX2DR  = 4'h0,
      TAP_UPDDR  = 4'h5,
      TAP_SELIR  = 4'h4,
      TAP_CAPIR  = 4'hE,
      TAP_SHIR   = 4'hA,
      TAP_EX1IR  = 4'h9,
      TAP_PAUIR  = 4'hB,
      TAP_EX2IR  = 4'h8,
      TAP_UPDIR  = 4'hD
   } tap_state_t;

   arb_state_t    state_q, state_d;
   logic [CW-1:0] gap_cnt_q, gap_cnt_d;
   logic          m0_gnt_q, m1_gnt_q;
   logic          tck_q;
   tap_state_t    tap_q;
   logic          tap_safe;

   function automatic arb_state_t pick_owner(input logic req0, input logic req1);
      if (req0)      return ST_OWN0;
      else if (req1) return ST_OWN1;
      else           return ST_IDLE;
   endfunction

   function automatic tap_state_t tap_next(input tap_state_t cur, input logic tms);
      case (cur)
         TAP_TLR:   return tms ? TAP_TLR   : TAP_RTI;
         TAP_RTI:   return tms ? TAP_SELDR : TAP_RTI;
         TAP_SELDR: return tms ? TAP_SELIR : TAP_CAPDR;
         TAP_CAPDR: return tms ? TAP_EX1DR : TAP_SHDR;
         TAP_SHDR:  return tms ? TAP_EX1DR : TAP_SHDR;
         TAP_EX1DR: return tms ? TAP_UPDDR : TAP_PAUDR;
         TAP_PAUDR: return tms ? TAP_EX2DR : TAP_PAUDR;
         TAP_EX2DR: return tms ? TAP_UPDDR : TAP_SHDR;
         TAP_UPDDR: return tms ? TAP_SELDR : TAP_RTI;
         TAP_SELIR: return tms ? TAP_TLR   : TAP_CAPIR;
         TAP_CAPIR: return tms ? TAP_EX1IR : TAP_SHIR;
         TAP_SHIR:  return tms ? TAP_EX1IR : TAP_SHIR;
         TAP_EX1IR: return tms ? TAP_UPDIR : TAP_PAUIR;
         TAP_PAUIR: return tms ? TAP_EX2IR : TAP_PAUIR;
         TAP_EX2IR: return tms ? TAP_UPDIR : TAP_SHIR;
         TAP_UPDIR: return tms ? TAP_SELDR : TAP_RTI;
         default:   return TAP_TLR;
      endcase
   endfunction

   assign tap_safe = (tap_q == TAP_TLR) || (tap_q == TAP_RTI);

   // Owner may only let go between scans, with TCK low, so the next owner starts clean.
   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         ST_IDLE: state_d = pick_owner(m0_req_i, m1_req_i);
         ST_OWN0: begin
            if (!m0_req_i && tap_safe && !tck_o) begin
               state_d   = ST_GAP;
               gap_cnt_d = CW'(SWITCH_GAP - 1);
            end
         end
         ST_OWN1: begin
            if (!m1_req_i && tap_safe && !tck_o) begin
               state_d   = ST_GAP;
               gap_cnt_d = CW'(SWITCH_GAP - 1);
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == '0) state_d = pick_owner(m0_req_i, m1_req_i);
            else                 gap_cnt_d = gap_cnt_q - CW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         gap_cnt_q <= '0;
         m0_gnt_q  <= 1'b0;
         m1_gnt_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_cnt_q <= gap_cnt_d;
         m0_gnt_q  <= (state_d == ST_OWN0);
         m1_gnt_q  <= (state_d == ST_OWN1);
      end
   end

   // Pins park in IDLE/GAP so the tracker sees no TCK edges across a handover.
   always_comb begin
      tck_o    = 1'b0;
      tms_o    = 1'b1;
      tdi_o    = 1'b0;
      trstn_o  = 1'b1;
      m0_tdo_o = 1'b0;
      m1_tdo_o = 1'b0;
      case (state_q)
         ST_OWN0: begin
            tck_o    = m0_tck_i;
            tms_o    = m0_tms_i;
            tdi_o    = m0_tdi_i;
            trstn_o  = m0_trstn_i;
            m0_tdo_o = tdo_i;
         end
         ST_OWN1: begin
            tck_o    = m1_tck_i;
            tms_o    = m1_tms_i;
            tdi_o    = m1_tdi_i;
            trstn_o  = m1_trstn_i;
            m1_tdo_o = tdo_i;
         end
         default: ;
      endcase
   end

   // TRST wins over a coincident TCK edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tck_q <= 1'b0;
         tap_q <= TAP_TLR;
      end else begin
         tck_q <= tck_o;
         if (!trstn_o)
            tap_q <= TAP_TLR;
         else if (tck_o && !tck_q)
            tap_q <= tap_next(tap_q, tms_o);
      end
   end

   assign m0_gnt_o    = m0_gnt_q;
   assign m1_gnt_o    = m1_gnt_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign tap_state_o = tap_q;

endmodule

// File: doc/jtag_arbiter.md
# jtag_arbiter

Two-master JTAG arbiter for the simulation top level. It shares the DUT debug port (tck/tms/tdi/trst_n/tdo) between the OpenOCD bridge master (m0) and a scripted bench or boot-sequence master (m1). It tracks the IEEE 1149.1 TAP state from the muxed pins. Ownership changes only when the TAP is in Test-Logic-Reset or Run-Test/Idle, and only after a parked gap, so neither master ever sees a half-shifted scan.

## Interface
- SWITCH_GAP, 4: number of clk_i cycles the pins are held parked between release and the next grant; legal values ≥1.
- clk_i  in  1  system clock. All JTAG inputs are synchronous to it, because TCK is generated in this domain.
- rst_ni  in  1  asynchronous, active-low reset.
- m0_req_i, m1_req_i  in  1  ownership request, level-held while ownership is wanted.
- m0_gnt_o, m1_gnt_o  out  1  ownership grant, registered.
- mN_tck_i, mN_tms_i, mN_tdi_i, mN_trstn_i  in  1 each  master N's JTAG drive.
- mN_tdo_o  out  1  DUT tdo when master N owns the port, else 0.
- tck_o, tms_o, tdi_o, trstn_o  out  1 each  muxed drive to the DUT.
- tdo_i  in  1  DUT tdo.
- tap_state_o  out  4  tracked TAP state (encoding below).
- busy_o  out  1  high whenever the FSM is not in IDLE.

## Operation
- Arbiter FSM states: IDLE, OWN0, OWN1, GAP. The state register alone drives the mux; the output mux is combinational from that register.
- IDLE: m0_req_i high → OWN0. Else m1_req_i high → OWN1. Else stay. m0 has fixed priority.
- OWNn: master n's tck/tms/tdi/trstn pass to the DUT; tdo_i passes to mN_tdo_o.
  - Go to GAP when mN_req_i is low, tap_safe holds (TAP is TLR or RTI), and tck_o is 0. Load the gap counter with SWITCH_GAP-1.
  - If the owner drops its request outside a safe TAP state, ownership is held. The owner must walk the TAP to TLR or RTI itself.
  - The other master's request is ignored. There is no preemption.
- GAP: pins parked. The counter decrements each cycle. When the counter reads 0, apply the IDLE decision in the same cycle (→ OWN0, OWN1 or IDLE). Requests are not sampled before the counter reaches 0.
- Parked pin values (IDLE and GAP): tck_o=0, tms_o=1, tdi_o=0, trstn_o=1. Both mN_tdo_o are 0.
- Grants: mN_gnt_o = (state==OWNn). busy_o = (state!=IDLE).
- TAP tracker:
  - A register tck_q holds the previous tck_o value. A rising TCK edge is (tck_o & ~tck_q).
  - On a rising edge, the tracker advances per the 1149.1 transition using tms_o.
  - If trstn_o is sampled 0, the tracker goes to TLR. This takes priority over any TCK edge in the same cycle.
- State encoding: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
- Parked pins in IDLE/GAP produce no TCK edges, so the tracker holds its state across handover.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, gap counter=0, tck_q=0, tracker=TLR (tap_state_o=F).
  - Outputs take their parked values. Both grants are 0; busy_o=0.
- Request to grant from IDLE: 1 cycle. A request sampled at edge k gives gnt high after edge k, and passthrough starts in the same cycle.
- Release to next grant: the release condition is sampled at edge k (OWN→GAP). The next owner is granted after edge k+SWITCH_GAP.
- A tracker update is visible on tap_state_o the cycle after the TCK rising edge is sampled. tap_safe uses the registered tracker value.
- tdo path: purely combinational, zero latency.
- Simultaneous requests in IDLE or at GAP end: m0 wins.
- A request that drops and re-asserts during GAP is sampled only when the counter reaches 0.
- Reset asserted mid-ownership: pins park immediately and the tracker returns to TLR. This does not wait for a safe TAP state.

## Test plan
- Reset: hold rst_ni=0 → tck_o=0, tms_o=1, trstn_o=1, tap_state_o=F, gnt=00, busy_o=0.
- m1_req only: m1 gets gnt one cycle later. m1 then gives 5 TCK pulses with TMS=1, then 1 pulse with TMS=0 → tap_state_o=C. tck_o/tms_o/tdi_o mirror m1, and m1_tdo_o follows tdo_i while m0_tdo_o=0.
- Both requests from IDLE: m0 is granted and m1 waits. m0 drops its request while in RTI at edge k → GAP for 4 cycles, pins parked, then m1_gnt high after edge k+4.
- m0 drops its request while in ShDR (2) → ownership kept. m0 drives TMS 1,1,0 → states 1, 5, C. Release happens only after C is reached with tck_o=0.
- The owner pulls trstn low while in ShIR (A) → tap_state_o=F the next cycle, with no TCK edge needed.
- rst_ni pulsed low during OWN1 in ShDR → grant drops and pins park asynchronously, tap_state_o=F. After reset release with m1_req still high, m1 is re-granted one cycle later.
